// File: rtl/alu_rr_scheduler.sv
// ============================================================================
// alu_rr_scheduler
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one N-bit ALU (AND/OR/XOR/ADD) between two requesters using
//   round-robin arbitration. Each requester has a valid/ready request channel
//   and a valid/ready response channel. Only one operation is ever in flight:
//   IDLE (arbitrate) -> EXEC (compute) -> RESP (hold result until consumed).
//
// Optional feature macro:
//   ALU_FLAGS_EN - when defined, adds the resp_zero / resp_neg outputs. These
//                  are registered alongside resp_data. When undefined, the
//                  ports and all flag logic are absent.
//
// Ports:
//   clk          in   1  clock, rising-edge
//   rst          in   1  asynchronous, active-high reset
//   req0_valid   in   1  requester 0 presents an operation
//   req0_ready   out  1  requester 0 operation accepted this cycle
//   req0_op      in   2  00 AND, 01 OR, 10 XOR, 11 ADD
//   req0_a       in   N  operand A
//   req0_b       in   N  operand B
//   req1_*            same set for requester 1
//   resp0_valid  out  1  result ready for requester 0
//   resp0_ready  in   1  requester 0 consumes result
//   resp1_valid  out  1  result ready for requester 1
//   resp1_ready  in   1  requester 1 consumes result
//   resp_data    out  N  result, shared by both responses
//   busy         out  1  high in EXEC or RESP
//   resp_zero    out  1  result == 0       (ALU_FLAGS_EN only)
//   resp_neg     out  1  result[N-1]       (ALU_FLAGS_EN only)
// ============================================================================
module alu_rr_scheduler #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [1:0]   req0_op,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [1:0]   req1_op,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         resp0_valid,
   input  logic         resp0_ready,
   output logic         resp1_valid,
   input  logic         resp1_ready,
   output logic [N-1:0] resp_data,
`ifdef ALU_FLAGS_EN
   output logic         resp_zero,
   output logic         resp_neg,
`endif
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t       r_state;
   logic         r_prio;
   logic         r_owner;
   logic [1:0]   r_op;
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;
   logic [N-1:0] r_data;
   logic         r_resp0_valid;
   logic         r_resp1_valid;
   logic         r_busy;
`ifdef ALU_FLAGS_EN
   logic         r_zero;
   logic         r_neg;
`endif

   logic         w_grant0;
   logic         w_grant1;
   logic         w_owner_ready;
   logic [N-1:0] w_result;

   // Round-robin arbiter. Grants are only offered in IDLE, so at most one
   // ready is high and both are low while an operation is in flight. The
   // reset term forces the readies low the instant reset is asserted, even
   // though a requester may still be presenting valid.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!rst && (r_state == IDLE)) begin
         if (req0_valid && req1_valid) begin
            w_grant0 = ~r_prio;
            w_grant1 = r_prio;
         end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
         end
      end
   end

   // The ALU itself. ADD wraps at N bits; the carry simply falls off.
   always_comb begin
      w_result = '0;
      case (r_op)
         2'b00:   w_result = r_a & r_b;
         2'b01:   w_result = r_a | r_b;
         2'b10:   w_result = r_a ^ r_b;
         default: w_result = r_a + r_b;
      endcase
   end

   // Only the owner's consume strobe matters; the other requester's
   // resp_ready is ignored while a result is being held.
   always_comb begin
      w_owner_ready = r_owner ? resp1_ready : resp0_ready;
   end

   // Main controller. IDLE latches the winning request and flips priority
   // to the other side, EXEC registers the ALU result (and flags when built),
   // RESP raises the owner's resp_valid and waits for that owner to consume.
   // resp_data is deliberately not cleared on return to IDLE so the last
   // result stays visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_prio        <= 1'b0;
         r_owner       <= 1'b0;
         r_op          <= 2'b00;
         r_a           <= '0;
         r_b           <= '0;
         r_data        <= '0;
         r_resp0_valid <= 1'b0;
         r_resp1_valid <= 1'b0;
         r_busy        <= 1'b0;
`ifdef ALU_FLAGS_EN
         r_zero        <= 1'b0;
         r_neg         <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant0 || w_grant1) begin
                  r_owner <= w_grant1;
                  r_prio  <= ~w_grant1;
                  r_op    <= w_grant1 ? req1_op : req0_op;
                  r_a     <= w_grant1 ? req1_a  : req0_a;
                  r_b     <= w_grant1 ? req1_b  : req0_b;
                  r_busy  <= 1'b1;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_data        <= w_result;
`ifdef ALU_FLAGS_EN
               r_zero        <= (w_result == '0);
               r_neg         <= w_result[N-1];
`endif
               r_resp0_valid <= ~r_owner;
               r_resp1_valid <= r_owner;
               r_state       <= RESP;
            end
            RESP: begin
               if (w_owner_ready) begin
                  r_resp0_valid <= 1'b0;
                  r_resp1_valid <= 1'b0;
                  r_busy        <= 1'b0;
                  r_state       <= IDLE;
               end
            end
            default: begin
               r_resp0_valid <= 1'b0;
               r_resp1_valid <= 1'b0;
               r_busy        <= 1'b0;
               r_state       <= IDLE;
            end
         endcase
      end
   end

   assign req0_ready  = w_grant0;
   assign req1_ready  = w_grant1;
   assign resp0_valid = r_resp0_valid;
   assign resp1_valid = r_resp1_valid;
   assign resp_data   = r_data;
   assign busy        = r_busy;
`ifdef ALU_FLAGS_EN
   assign resp_zero   = r_zero;
   assign resp_neg    = r_neg;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ============================================================================
// tb_alu_rr_scheduler
// ----------------------------------------------------------------------------
// Directed and randomized checks of alu_rr_scheduler against a small
// transaction-level reference model (round-robin winner pick plus an
// arithmetic ALU function). Inputs change on the falling edge; all outputs
// are sampled 1 ns after the falling edge, well away from the rising edge.
// Flag outputs are checked when ALU_FLAGS_EN is defined.
// ============================================================================
module tb_alu_rr_scheduler;

   logic        clock;
   logic        reset;
   logic        req0Valid;
   logic        req0Ready;
   logic [1:0]  req0Op;
   logic [31:0] req0A;
   logic [31:0] req0B;
   logic        req1Valid;
   logic        req1Ready;
   logic [1:0]  req1Op;
   logic [31:0] req1A;
   logic [31:0] req1B;
   logic        resp0Valid;
   logic        resp0Ready;
   logic        resp1Valid;
   logic        resp1Ready;
   logic [31:0] respData;
   logic        busy;
`ifdef ALU_FLAGS_EN
   logic        respZero;
   logic        respNeg;
`endif

   int checks   = 0;
   int failures = 0;
   int modelPrio = 0;

   alu_rr_scheduler #(.N(32)) dut (
      .clk         (clock),
      .rst         (reset),
      .req0_valid  (req0Valid),
      .req0_ready  (req0Ready),
      .req0_op     (req0Op),
      .req0_a      (req0A),
      .req0_b      (req0B),
      .req1_valid  (req1Valid),
      .req1_ready  (req1Ready),
      .req1_op     (req1Op),
      .req1_a      (req1A),
      .req1_b      (req1B),
      .resp0_valid (resp0Valid),
      .resp0_ready (resp0Ready),
      .resp1_valid (resp1Valid),
      .resp1_ready (resp1Ready),
      .resp_data   (respData),
`ifdef ALU_FLAGS_EN
      .resp_zero   (respZero),
      .resp_neg    (respNeg),
`endif
      .busy        (busy)
   );

   // Free-running 100 MHz clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Safety net so a stuck run still reports and ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference ALU: plain arithmetic, sum taken modulo 2^32.
   function automatic logic [31:0] aluRef(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] sum;
      sum = {32'h0, a} + {32'h0, b};
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return sum[31:0];
      endcase
   endfunction

   // One comparison point: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present a new request on one side and hold it until granted.
   task automatic applyStimulus(input int side, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b);
      if (side == 0) begin
         req0Valid = 1'b1; req0Op = op; req0A = a; req0B = b;
      end else begin
         req1Valid = 1'b1; req1Op = op; req1A = a; req1B = b;
      end
   endtask

   // Random request with a bias toward operand pairs whose ADD wraps to zero.
   task automatic randomRequest(input int side);
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = (~a) + 32'd1;
      applyStimulus(side, 2'($urandom_range(0, 3)), a, b);
   endtask

   // One idle cycle with nothing valid: no grant, nothing busy.
   task automatic idleCycle;
      #1;
      checkOutput("idleReady0", 32'(req0Ready), 32'd0);
      checkOutput("idleReady1", 32'(req1Ready), 32'd0);
      checkOutput("idleBusy", 32'(busy), 32'd0);
      @(posedge clock);
      @(negedge clock);
   endtask

   // Drive one complete transaction from IDLE: predicted grant, EXEC,
   // RESP held for 'hold' extra cycles, then consumption. Called just after
   // a falling edge with the request inputs already in place.
   task automatic serveOne(input int hold);
      int          w;
      logic [31:0] res;
      #1;
      if (req0Valid && req1Valid) w = modelPrio;
      else if (req0Valid)         w = 0;
      else                        w = 1;
      checkOutput("grantReady0", 32'(req0Ready), 32'(w == 0));
      checkOutput("grantReady1", 32'(req1Ready), 32'(w == 1));
      res = (w == 0) ? aluRef(req0Op, req0A, req0B) : aluRef(req1Op, req1A, req1B);
      modelPrio = 1 - w;
      @(posedge clock);
      @(negedge clock);
      // Winner withdraws and scribbles its operands: the DUT must have latched them.
      if (w == 0) begin req0Valid = 1'b0; req0A = $urandom; req0B = $urandom; end
      else        begin req1Valid = 1'b0; req1A = $urandom; req1B = $urandom; end
      #1;
      checkOutput("execBusy", 32'(busy), 32'd1);
      checkOutput("execReady0", 32'(req0Ready), 32'd0);
      checkOutput("execReady1", 32'(req1Ready), 32'd0);
      checkOutput("execResp0", 32'(resp0Valid), 32'd0);
      checkOutput("execResp1", 32'(resp1Valid), 32'd0);
      @(posedge clock);
      @(negedge clock);
      #1;
      checkOutput("respValid0", 32'(resp0Valid), 32'(w == 0));
      checkOutput("respValid1", 32'(resp1Valid), 32'(w == 1));
      checkOutput("respData", respData, res);
`ifdef ALU_FLAGS_EN
      checkOutput("respZero", 32'(respZero), 32'(res == 32'd0));
      checkOutput("respNeg", 32'(respNeg), 32'(res[31]));
`endif
      for (int i = 0; i < hold; i++) begin
         if (w == 0) resp1Ready = 1'b1; else resp0Ready = 1'b1;
         @(posedge clock);
         @(negedge clock);
         #1;
         checkOutput("holdValid", 32'(w == 0 ? resp0Valid : resp1Valid), 32'd1);
         checkOutput("holdOther", 32'(w == 0 ? resp1Valid : resp0Valid), 32'd0);
         checkOutput("holdData", respData, res);
         checkOutput("holdBusy", 32'(busy), 32'd1);
         checkOutput("holdReady", 32'(req0Ready | req1Ready), 32'd0);
      end
      resp0Ready = (w == 0);
      resp1Ready = (w == 1);
      @(posedge clock);
      @(negedge clock);
      resp0Ready = 1'b0;
      resp1Ready = 1'b0;
      #1;
      checkOutput("doneResp0", 32'(resp0Valid), 32'd0);
      checkOutput("doneResp1", 32'(resp1Valid), 32'd0);
      checkOutput("doneBusy", 32'(busy), 32'd0);
      checkOutput("keptData", respData, res);
   endtask

   // Directed steps followed by a randomized phase, then the summary.
   initial begin
      reset = 1'b1;
      req0Valid = 1'b1; req0Op = 2'b11; req0A = 32'h1; req0B = 32'h2;
      req1Valid = 1'b1; req1Op = 2'b11; req1A = 32'h3; req1B = 32'h4;
      resp0Ready = 1'b0; resp1Ready = 1'b0;
      #2;
      checkOutput("rstReady0", 32'(req0Ready), 32'd0);
      checkOutput("rstReady1", 32'(req1Ready), 32'd0);
      checkOutput("rstResp0", 32'(resp0Valid), 32'd0);
      checkOutput("rstResp1", 32'(resp1Valid), 32'd0);
      checkOutput("rstData", respData, 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      @(negedge clock);
      req0Valid = 1'b0;
      req1Valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      modelPrio = 0;
      idleCycle();

      $display("[TB] XOR single requester");
      applyStimulus(0, 2'b10, 32'h2, 32'h1);
      serveOne(0);

      $display("[TB] simultaneous requests");
      idleCycle();
      applyStimulus(0, 2'b00, 32'hF, 32'h5);
      applyStimulus(1, 2'b01, 32'hF, 32'h5);
      serveOne(0);
      serveOne(1);
      applyStimulus(0, 2'b00, 32'hA5A5A5A5, 32'h0FF00FF0);
      applyStimulus(1, 2'b10, 32'h12345678, 32'h87654321);
      serveOne(2);
      serveOne(0);

      $display("[TB] wrap-around ADD and negative XOR");
      applyStimulus(1, 2'b11, 32'hFFFFFFFF, 32'h1);
      serveOne(0);
      applyStimulus(0, 2'b10, 32'h55555555, 32'hF222222F);
      serveOne(0);

      $display("[TB] response back-pressure");
      applyStimulus(0, 2'b11, 32'h00001000, 32'h00000234);
      applyStimulus(1, 2'b01, 32'h00F0, 32'h0F00);
      serveOne(5);
      serveOne(0);

      $display("[TB] reset during EXEC");
      applyStimulus(0, 2'b11, 32'h11111111, 32'h22222222);
      @(posedge clock);
      @(negedge clock);
      applyStimulus(1, 2'b01, 32'h1, 32'h2);
      reset = 1'b1;
      #1;
      checkOutput("abortReady0", 32'(req0Ready), 32'd0);
      checkOutput("abortReady1", 32'(req1Ready), 32'd0);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortResp0", 32'(resp0Valid), 32'd0);
      checkOutput("abortResp1", 32'(resp1Valid), 32'd0);
      checkOutput("abortData", respData, 32'd0);
`ifdef ALU_FLAGS_EN
      checkOutput("abortZero", 32'(respZero), 32'd0);
      checkOutput("abortNeg", 32'(respNeg), 32'd0);
`endif
      @(negedge clock);
      req0Valid = 1'b0;
      req1Valid = 1'b0;
      reset = 1'b0;
      modelPrio = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checkOutput("postAbortResp", 32'(resp0Valid | resp1Valid), 32'd0);
         idleCycle();
      end
      checkOutput("postAbortData", respData, 32'd0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 40; n++) begin
         if (!req0Valid && ($urandom_range(0, 1) == 1)) randomRequest(0);
         if (!req1Valid && ($urandom_range(0, 1) == 1)) randomRequest(1);
         if (!req0Valid && !req1Valid) idleCycle();
         else serveOne(int'($urandom_range(0, 3)));
      end
      while (req0Valid || req1Valid) serveOne(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
